horizontal_timing_generator: RTL

- Upstream stage of the vertical line counter. Divides the system clock into a pixel-rate strobe and counts pixels per line.
- Decodes the line into active / front-porch / sync / back-porch phases.
- Drives `horizontal_clock`, the active-low hsync level. The vertical counter advances on the falling edge of `horizontal_clock`, so that edge occurs exactly once per line.
- Also provides `video_active`, `pixel_x` and a `line_end` strobe for downstream pixel logic.

---
 rtl/vga_timing_pkg.sv | 24 ++
 rtl/pixel_clock_divider.sv | 28 ++
 rtl/horizontal_timing_generator.sv | 81 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the horizontal line-phase type
// used by the horizontal and vertical timing generators.
package vga_timing_pkg;

  localparam int COUNT_W = 10;

  localparam int H_ACTIVE_DEFAULT     = 640;
  localparam int H_SYNC_START_DEFAULT = 656;
  localparam int H_SYNC_END_DEFAULT   = 752;
  localparam int H_TOTAL_DEFAULT      = 800;

  localparam int V_SYNC_START_DEFAULT = 490;
  localparam int V_SYNC_END_DEFAULT   = 492;
  localparam int V_TOTAL_DEFAULT      = 521;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } h_state_t;

endpackage

// File: rtl/pixel_clock_divider.sv
// Divides the system clock down to a one-cycle pixel strobe, decoded
// directly from the divider register so it cannot glitch.
module pixel_clock_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clock,
  input  logic res,
  output logic pixel_tick
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_count;

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      div_count <= '0;
    end else if (div_count == DIV_LAST) begin
      div_count <= '0;
    end else begin
      div_count <= div_count + 1'b1;
    end
  end

  assign pixel_tick = (div_count == DIV_LAST);

endmodule

// File: rtl/horizontal_timing_generator.sv
// Counts pixels per line, tracks the line phase and drives hsync
// (horizontal_clock) plus visible-region qualifiers for pixel logic.
module horizontal_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = H_ACTIVE_DEFAULT,
  parameter int H_SYNC_START = H_SYNC_START_DEFAULT,
  parameter int H_SYNC_END   = H_SYNC_END_DEFAULT,
  parameter int H_TOTAL      = H_TOTAL_DEFAULT
) (
  input  logic               clock,
  input  logic               res,
  output logic               horizontal_clock,
  output logic               pixel_tick,
  output logic               video_active,
  output logic [COUNT_W-1:0] pixel_x,
  output logic               line_end
);

  localparam logic [COUNT_W-1:0] ACTIVE_END  = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] SYNC_BEGIN  = COUNT_W'(H_SYNC_START);
  localparam logic [COUNT_W-1:0] SYNC_FINISH = COUNT_W'(H_SYNC_END);
  localparam logic [COUNT_W-1:0] LINE_LAST   = COUNT_W'(H_TOTAL - 1);

  h_state_t           state;
  h_state_t           state_next;
  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] h_inc;
  logic [COUNT_W-1:0] h_next;

  pixel_clock_divider #(
    .CLK_DIV(CLK_DIV)
  ) u_divider (
    .clock     (clock),
    .res       (res),
    .pixel_tick(pixel_tick)
  );

  assign h_inc = (h_count == LINE_LAST) ? '0 : h_count + 1'b1;

  // Phase changes are decided on the count the next tick will commit,
  // so state and registered outputs always describe the same pixel.
  always_comb begin
    state_next = state;
    h_next     = h_inc;
    unique case (state)
      IDLE: begin
        h_next     = h_count;
        state_next = ACTIVE;
      end
      ACTIVE:  if (h_inc == ACTIVE_END)  state_next = FRONT;
      FRONT:   if (h_inc == SYNC_BEGIN)  state_next = SYNC;
      SYNC:    if (h_inc == SYNC_FINISH) state_next = BACK;
      BACK:    if (h_inc == '0)          state_next = ACTIVE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge res) begin
    if (!res) begin
      state            <= IDLE;
      h_count          <= '0;
      horizontal_clock <= 1'b1;
      video_active     <= 1'b0;
      pixel_x          <= '0;
      line_end         <= 1'b0;
    end else begin
      line_end <= 1'b0;
      if (pixel_tick) begin
        state            <= state_next;
        h_count          <= h_next;
        horizontal_clock <= (state_next != SYNC);
        video_active     <= (state_next == ACTIVE);
        pixel_x          <= (state_next == ACTIVE) ? h_next : '0;
        line_end         <= (state == BACK) && (state_next == ACTIVE);
      end
    end
  end

endmodule
